// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings and the LSU state type.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: legality check on the incoming
// access, byte-enable/replication for stores, extract/extend for loads.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        chk_we,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_addr_lo,
    output logic        chk_legal,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decide whether the access about to be accepted is encodable and aligned.
    always_comb begin
        chk_legal = 1'b0;
        if (chk_we) begin
            case (chk_funct3)
                F3_SB:   chk_legal = 1'b1;
                F3_SH:   chk_legal = ~chk_addr_lo[0];
                F3_SW:   chk_legal = (chk_addr_lo == 2'b00);
                default: chk_legal = 1'b0;
            endcase
        end else begin
            case (chk_funct3)
                F3_LB, F3_LBU: chk_legal = 1'b1;
                F3_LH, F3_LHU: chk_legal = ~chk_addr_lo[0];
                F3_LW:         chk_legal = (chk_addr_lo == 2'b00);
                default:       chk_legal = 1'b0;
            endcase
        end
    end

    // Place store data on every lane of its size and enable only the target bytes.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = 32'h0;
        if (we) begin
            case (funct3)
                F3_SB: begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    wdata_lane = wdata;
                end
            endcase
        end
    end

    // Pick the addressed byte/halfword out of the read word and extend it.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit: turns one RV32I load/store into a single request/response
// transaction on the data bus, stalls the core meanwhile, and reports
// misaligned/illegal accesses and bus timeouts with the completion pulse.
module lsu_mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_misaligned,
    output logic        lsu_bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state, next_state;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [2:0]       funct3_q;
    logic             we_q, mis_q, err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             legal, timeout;
    logic [3:0]       be;
    logic [31:0]      wdata_lane, load_data;

    lsu_align u_align (
        .chk_we      (lsu_we),
        .chk_funct3  (lsu_funct3),
        .chk_addr_lo (lsu_addr[1:0]),
        .chk_legal   (legal),
        .we          (we_q),
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .be          (be),
        .wdata_lane  (wdata_lane),
        .load_data   (load_data)
    );

    // State register; reset returns to IDLE at once so mem_req drops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; a response arriving on the last allowed cycle still wins over the timeout.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            IDLE: if (lsu_valid) next_state = legal ? REQ : DONE;
            REQ: begin
                if (cnt_q == CNT_LAST) begin
                    next_state = DONE;
                    timeout    = 1'b1;
                end else if (mem_gnt) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    next_state = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    next_state = DONE;
                    timeout    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the access, run the timeout counter and register the result for DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'h0;
            we_q     <= 1'b0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_valid) begin
                        addr_q   <= lsu_addr;
                        wdata_q  <= lsu_wdata;
                        funct3_q <= lsu_funct3;
                        we_q     <= lsu_we;
                        cnt_q    <= '0;
                        mis_q    <= ~legal;
                        err_q    <= 1'b0;
                        if (!legal) rdata_q <= 32'h0;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                end
                RESP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid) begin
                        rdata_q <= we_q ? 32'h0 : load_data;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu_stall      = rst_n & lsu_valid & (state != DONE);
    assign lsu_done       = (state == DONE);
    assign lsu_misaligned = lsu_done & mis_q;
    assign lsu_bus_err    = lsu_done & err_q;
    assign lsu_rdata      = rdata_q;

    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be : 4'h0;
    assign mem_wdata = mem_req ? wdata_lane : 32'h0;

endmodule
